debug_display_pager: RTL

Parametrised successor to the fixed 2-bit-switch HEX debug mux in the game top level. It takes N_PAGES debug words of DIGITS hex nibbles each. Operating modes are manual page select, timed auto-scroll, and freeze, where the selected page is snapshotted. Output is registered 7-segment patterns for the board displays; the unit sits at the top level between datapath debug buses and the HEX outputs.

---
 rtl/debug_display_pager_pkg.sv | 28 ++
 rtl/debug_display_pager_hexa7seg.sv | 30 +++
 rtl/debug_display_pager.sv | 128 ++++++++++++
 3 files changed

// File: rtl/debug_display_pager_pkg.sv
// Shared encodings for the debug display pager: mode inputs, pager states
// and the blank 7-segment pattern.
package debug_display_pager_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_FREEZE = 2'b10;
    localparam logic [1:0] MODE_BLANK  = 2'b11;

    typedef enum logic [1:0] {
        ST_MANUAL,
        ST_AUTO,
        ST_FREEZE,
        ST_BLANK
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic state_e mode_to_state(input logic [1:0] m);
        case (m)
            MODE_AUTO:   return ST_AUTO;
            MODE_FREEZE: return ST_FREEZE;
            MODE_BLANK:  return ST_BLANK;
            default:     return ST_MANUAL;
        endcase
    endfunction

endpackage

// File: rtl/debug_display_pager_hexa7seg.sv
// Nibble to active-low 7-segment decoder (segment g is bit 6, a is bit 0).
module hexa7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/debug_display_pager.sv
// Pages N_PAGES debug words onto DIGITS seven-segment displays with manual,
// auto-scroll, freeze (snapshot) and blank modes; all outputs registered.
module debug_display_pager
    import debug_display_pager_pkg::*;
#(
    parameter int N_PAGES      = 4,
    parameter int DIGITS       = 6,
    parameter int SCROLL_TICKS = 50000000,
    parameter int PAGE_W       = (N_PAGES > 1) ? $clog2(N_PAGES) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_PAGES*DIGITS*4-1:0] page_data,
    input  logic [PAGE_W-1:0]           page_sel,
    input  logic [1:0]                  mode,
    input  logic                        advance,
    output logic [DIGITS*7-1:0]         hex,
    output logic [PAGE_W-1:0]           page_idx,
    output logic                        frozen
);

    localparam int TICK_W = $clog2(SCROLL_TICKS);
    localparam int WORD_W = DIGITS * 4;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCROLL_TICKS - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(N_PAGES - 1);
    localparam logic [PAGE_W:0]   N_PAGES_W = (PAGE_W + 1)'(N_PAGES);

    state_e              state_q, state_d;
    logic [PAGE_W-1:0]   cur_page_q, cur_page_d;
    logic [TICK_W-1:0]   tick_q, tick_d, tick_eff;
    logic [WORD_W-1:0]   snapshot_q, snapshot_d;
    logic [DIGITS*7-1:0] hex_q, hex_d;
    logic [PAGE_W-1:0]   page_idx_q, page_idx_d;
    logic                frozen_q, frozen_d;
    logic [WORD_W-1:0]   nibbles;
    logic [DIGITS*7-1:0] seg_w;
    logic                show_blank;

    // Explicit mux so an out-of-range page selects zero rather than X.
    function automatic logic [WORD_W-1:0] page_slice(
        input logic [N_PAGES*WORD_W-1:0] data,
        input logic [PAGE_W-1:0]         idx
    );
        logic [WORD_W-1:0] w;
        w = '0;
        for (int p = 0; p < N_PAGES; p++) begin
            if (idx == PAGE_W'(p)) w = data[p*WORD_W +: WORD_W];
        end
        return w;
    endfunction

    function automatic logic page_valid(input logic [PAGE_W-1:0] idx);
        return {1'b0, idx} < N_PAGES_W;
    endfunction

    function automatic logic [PAGE_W-1:0] next_page(input logic [PAGE_W-1:0] idx);
        return (idx >= PAGE_LAST) ? '0 : idx + PAGE_W'(1);
    endfunction

    always_comb begin
        state_d    = mode_to_state(mode);
        cur_page_d = cur_page_q;
        tick_d     = tick_q;
        snapshot_d = snapshot_q;
        frozen_d   = 1'b0;
        // Entering AUTO from any other state restarts the page timer.
        tick_eff   = (state_q == ST_AUTO) ? tick_q : '0;
        case (state_d)
            ST_MANUAL: begin
                cur_page_d = page_sel;
                tick_d     = '0;
            end
            ST_AUTO: begin
                if (advance || (tick_eff == TICK_LAST)) begin
                    cur_page_d = next_page(cur_page_q);
                    tick_d     = '0;
                end else begin
                    tick_d = tick_eff + TICK_W'(1);
                end
            end
            ST_FREEZE: begin
                frozen_d = 1'b1;
                if (state_q != ST_FREEZE) snapshot_d = page_slice(page_data, cur_page_q);
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        nibbles    = (state_d == ST_FREEZE) ? snapshot_d : page_slice(page_data, cur_page_d);
        show_blank = (state_d == ST_BLANK) || !page_valid(cur_page_d);
        hex_d      = show_blank ? {DIGITS{SEG_BLANK}} : seg_w;
        page_idx_d = cur_page_d;
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        hexa7seg u_hexa7seg (
            .nibble (nibbles[d*4 +: 4]),
            .seg    (seg_w[d*7 +: 7])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_MANUAL;
            cur_page_q <= '0;
            tick_q     <= '0;
            snapshot_q <= '0;
            hex_q      <= {DIGITS{SEG_BLANK}};
            page_idx_q <= '0;
            frozen_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_page_q <= cur_page_d;
            tick_q     <= tick_d;
            snapshot_q <= snapshot_d;
            hex_q      <= hex_d;
            page_idx_q <= page_idx_d;
            frozen_q   <= frozen_d;
        end
    end

    assign hex      = hex_q;
    assign page_idx = page_idx_q;
    assign frozen   = frozen_q;

endmodule
